// File: rtl/ifu_fetch_pkg.sv
// ifu_fetch_pkg: shared constants and FSM encoding for the instruction fetch unit
package ifu_fetch_pkg;
    localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;
    localparam int PC_INC = 4;
    typedef enum logic [1:0] {BOOT, FETCH, DRAIN} state_t;
endpackage

// File: rtl/ifu_fetch_fifo.sv
// ifu_fetch_fifo: synchronous FIFO holding {instr, pc} pairs for the fetch unit
// Ports: clk, rst_n (async active-low); push/din write; pop reads head (dout);
//        flush empties the buffer and wins over push/pop; count/full/empty status.
//        The caller must not push when full.
module ifu_fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic do_pop;
    assign full   = count == CW'(DEPTH);
    assign empty  = count == '0;
    assign dout   = mem[rd_ptr];
    assign do_pop = pop && !empty;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(do_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction fetch unit - PC generation, imem reads, buffered {instr, pc} to decode
// Ports: clk, rst_n (async active-low); redirect/redirect_pc restart the stream;
//        imem_req/imem_addr/imem_gnt request channel, imem_rvalid/imem_rdata in-order responses;
//        if_valid/if_ready/if_instr/if_pc handshake toward decode.
module ifu_fetch
    import ifu_fetch_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0,
    parameter int                    FIFO_DEPTH = 2,
    parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = DATA_WIDTH'(NOP_INSTR_DEF)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  redirect,
    input  logic [DATA_WIDTH-1:0] redirect_pc,
    output logic                  imem_req,
    output logic [DATA_WIDTH-1:0] imem_addr,
    input  logic                  imem_gnt,
    input  logic                  imem_rvalid,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    output logic                  if_valid,
    input  logic                  if_ready,
    output logic [DATA_WIDTH-1:0] if_instr,
    output logic [DATA_WIDTH-1:0] if_pc
);
    localparam int DW = DATA_WIDTH;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    state_t state;
    logic [DW-1:0] fetch_pc, rsp_pc, last_pc, head_instr, head_pc, target;
    logic [CW-1:0] outstanding, discard, fifo_count, new_discard;
    logic [CW:0] inflight;
    logic fifo_full, fifo_empty, grant, push, pop, drop;
    assign target      = redirect_pc & ~DW'(3);
    assign inflight    = {1'b0, outstanding} + {1'b0, fifo_count};
    // outstanding + buffered never exceeds the FIFO, so every live response has a slot
    assign imem_req    = state == FETCH && !redirect && inflight < (CW+1)'(FIFO_DEPTH);
    assign imem_addr   = fetch_pc;
    assign grant       = imem_req && imem_gnt;
    assign push        = imem_rvalid && discard == '0 && !redirect && !fifo_full;
    assign drop        = imem_rvalid && discard != '0;
    assign pop         = if_valid && if_ready && !redirect;
    assign new_discard = discard + outstanding - CW'(imem_rvalid);
    assign if_valid    = !fifo_empty;
    assign if_instr    = fifo_empty ? NOP_INSTR : head_instr;
    assign if_pc       = fifo_empty ? last_pc : head_pc;
    ifu_fetch_fifo #(.WIDTH(2*DW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (redirect),
        .din   ({imem_rdata, rsp_pc}),
        .dout  ({head_instr, head_pc}),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );
    // rsp_pc is the address of the next live response; stale ones are never pushed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= BOOT;
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            last_pc     <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            if (!fifo_empty) last_pc <= head_pc;
            if (redirect) begin
                fetch_pc    <= target;
                rsp_pc      <= target;
                outstanding <= '0;
                discard     <= new_discard;
                state       <= new_discard != '0 ? DRAIN : FETCH;
            end else begin
                if (grant) fetch_pc <= fetch_pc + DW'(PC_INC);
                if (push) rsp_pc <= rsp_pc + DW'(PC_INC);
                outstanding <= outstanding + CW'(grant) - CW'(push);
                discard     <= discard - CW'(drop);
                state       <= state == BOOT ? FETCH :
                               (state == DRAIN && discard == CW'(drop)) ? FETCH : state;
            end
        end
    end
endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
- Instruction fetch unit; the producer end of the instruction path that feeds the decode/control stage.
- Generates the PC and issues word reads to instruction memory.
- Buffers returned words in a small FIFO and presents {instr, pc} to decode over a valid/ready handshake.
- Redirect input (branch/jal/jalr target from execute) flushes buffered and in-flight fetches.

Parameters:
- DATA_WIDTH, 32, instruction/address width.
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- FIFO_DEPTH, 2, instruction buffer entries (power of two, ≥2).
- NOP_INSTR, 32'h0000_0013, value driven on if_instr when no valid instruction (addi x0,x0,0).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- redirect  in  1  pulse: discard fetch stream, restart at redirect_pc
- redirect_pc  in  DATA_WIDTH  new fetch target
- imem_req  out  1  read request
- imem_addr  out  DATA_WIDTH  word-aligned read address
- imem_gnt  in  1  request accepted this cycle (handshake when imem_req & imem_gnt)
- imem_rvalid  in  1  read data valid (in order, latency ≥1 cycle after grant)
- imem_rdata  in  DATA_WIDTH  read data
- if_valid  out  1  if_instr/if_pc valid
- if_ready  in  1  decode accepts (transfer when if_valid & if_ready)
- if_instr  out  DATA_WIDTH  instruction word to decode
- if_pc  out  DATA_WIDTH  address of if_instr

Behaviour:
- Clock and reset: one clock clk; asynchronous active-low reset rst_n.
- Reset values: state=BOOT, fetch_pc=RESET_PC, FIFO empty, outstanding=0, discard=0, imem_req=0, if_valid=0, if_instr=NOP_INSTR, if_pc=RESET_PC.
- FSM states:
  - BOOT: no request; next cycle → FETCH.
  - FETCH: normal issue.
  - DRAIN: discard>0; no requests; → FETCH when discard reaches 0 (including the cycle the last discarded rvalid arrives).
- Issue rule (FETCH only):
  - imem_req=1 iff outstanding + fifo_count < FIFO_DEPTH; imem_addr=fetch_pc.
  - On gnt: fetch_pc += 4, outstanding++.
  - Request and address must stay stable until granted, unless a redirect occurs.
- Response:
  - imem_rvalid with discard=0: push {imem_rdata, pc_of_response} into FIFO, outstanding--.
  - Response PC tracked in a parallel FIFO or computed from a head-PC register.
  - The issue rule guarantees no overflow; an rvalid with a full FIFO is a protocol violation to be flagged by a bench assertion.
- Output: FIFO head drives if_instr/if_pc; if_valid = !empty. When empty, if_instr=NOP_INSTR and if_pc holds its last value. Pop on if_valid & if_ready.
- Latency: from reset deassertion with gnt tied 1 and 1-cycle rvalid, first if_valid in cycle 3 (BOOT, req, rvalid→FIFO, visible next).
- Simultaneous push+pop: both apply; count unchanged.
- Redirect has highest priority; in the redirect cycle:
  - FIFO flushed; any rvalid that cycle dropped.
  - Any pop that cycle ignored for FIFO state (decode must treat the redirect as a kill).
  - fetch_pc ← {redirect_pc[31:2],2'b00}; imem_req forced 0.
  - discard ← outstanding minus (1 if rvalid this cycle); outstanding ← 0.
  - Next state: DRAIN if new discard>0, else FETCH.
  - A grant in the redirect cycle cannot occur because req=0.
- Redirect during DRAIN: discard continues counting down (any rvalid that cycle still decrements); target updated.
- fetch_pc wraps modulo 2^DATA_WIDTH (0xFFFF_FFFC+4 → 0).
- Reset asserted mid-operation: all state returns to reset values immediately. Responses arriving after reset are ignored because outstanding=0; the bench must not generate them.

Decomposition:
- Shared package/include: NOP_INSTR, FSM state encodings (BOOT/FETCH/DRAIN), PC increment constant 4.
- One sub-module natural: ifu_fifo (sync FIFO, width 2*DATA_WIDTH, depth FIFO_DEPTH, push/pop/flush, count, full/empty).

Test Plan:
1. Reset release, gnt=1, 1-cycle rvalid, rdata=addr^32'hA5A5_0000, if_ready=1 → if_pc sequence 0,4,8,12 with matching instr; first if_valid in cycle 3.
2. if_ready=0 for 10 cycles → FIFO fills to 2; imem_req drops; if_instr/if_pc at 0 held stable. Release → 4,8 follow with no gaps or duplicates.
3. imem_gnt=0 for 3 cycles at addr 8 → imem_req=1, imem_addr=8 held stable; 8 issued once on grant.
4. Redirect to 0x100 with 2 outstanding, rvalid latency 3 → the two stale words are never presented. DRAIN lasts until both return, then if_pc=0x100,0x104.
5. Redirect to 0x203 in the same cycle as rvalid and a pop → that word dropped; next if_pc=0x200; discard=outstanding-1.
6. RESET_PC=32'hFFFF_FFF8 → if_pc FFFF_FFF8, FFFF_FFFC, 0000_0000. rst_n asserted mid-stream → if_valid=0 and imem_req=0 asynchronously.
